// File: rtl/pipeline_hazard_controller_if.sv
// Hazard/wait indications from the datapath and the per-register stall/nullify
// controls returned to it. The datapath uses the master side; the controller uses the slave side.
interface pipeline_hazard_controller_if #(
   parameter int N_STAGES = 4
);
   logic                load_use;
   logic                mdu_read;
   logic                mdu_start;
   logic                imem_wait;
   logic                dmem_wait;
   logic                exc_valid;
   logic                pc_stall;
   logic [N_STAGES-1:0] stall;
   logic [N_STAGES-1:0] nullify;
   logic                exc_redirect;
   logic                mdu_busy;

   modport master (
      output load_use, mdu_read, mdu_start, imem_wait, dmem_wait, exc_valid,
      input  pc_stall, stall, nullify, exc_redirect, mdu_busy
   );

   modport slave (
      input  load_use, mdu_read, mdu_start, imem_wait, dmem_wait, exc_valid,
      output pc_stall, stall, nullify, exc_redirect, mdu_busy
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Sequences the F/D, D/E, E/M, M/W registers and the PC: post-reset flush,
// hazard stalls, exception flush and the multicycle MDU busy counter.
module pipeline_hazard_controller #(
   parameter int N_STAGES    = 4,
   parameter int MDU_LATENCY = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   pipeline_hazard_controller_if.slave   hif
);
   localparam int INIT_W = $clog2(N_STAGES + 1);
   localparam int MDU_W  = $clog2(MDU_LATENCY + 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(N_STAGES - 1);
   localparam logic [MDU_W-1:0]  MDU_LOAD  = MDU_W'(MDU_LATENCY);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_EXC} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [INIT_W-1:0]   r_initCnt;
   logic [MDU_W-1:0]    r_mduCnt;
   logic                w_mduBusy;
   logic                w_mduAccept;
   logic                w_hazard;
   logic                w_pcStall;
   logic [N_STAGES-1:0] w_stall;
   logic [N_STAGES-1:0] w_nullify;
   logic                w_excRedirect;

   assign w_mduBusy   = (r_mduCnt != '0);
   assign w_hazard    = hif.load_use | (hif.mdu_read & w_mduBusy);
   assign w_mduAccept = hif.mdu_start & (r_state != S_INIT) & ~hif.exc_valid & ~hif.dmem_wait;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_INIT;
         r_initCnt <= '0;
         r_mduCnt  <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_INIT) begin
            r_initCnt <= r_initCnt + 1'b1;
         end
         if (w_mduAccept) begin
            r_mduCnt <= MDU_LOAD;
         end else if (w_mduBusy) begin
            r_mduCnt <= r_mduCnt - 1'b1;
         end
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_pcStall     = 1'b0;
      w_stall       = '0;
      w_nullify     = '0;
      w_excRedirect = 1'b0;
      if (r_state == S_INIT) begin
         w_nullify = '1;
         w_pcStall = 1'b1;
         if (r_initCnt == INIT_LAST) begin
            w_nextState = S_RUN;
         end
      end else begin
         if (hif.exc_valid) begin
            w_nullify     = '1;
            w_excRedirect = 1'b1;
         end else if (hif.dmem_wait) begin
            w_stall   = '1;
            w_pcStall = 1'b1;
         end else if (w_hazard) begin
            w_pcStall  = 1'b1;
            w_stall[0] = 1'b1;
            w_nullify[1] = 1'b1;
         end else if (hif.imem_wait) begin
            w_pcStall    = 1'b1;
            w_nullify[0] = 1'b1;
         end
         // In EXC the old-PC fetch must be killed; it only lands once F/D is not stalled.
         if (r_state == S_EXC) begin
            w_nullify[0] = 1'b1;
            w_nextState  = (hif.exc_valid || w_stall[0]) ? S_EXC : S_RUN;
         end else begin
            w_nextState  = hif.exc_valid ? S_EXC : S_RUN;
         end
      end
   end

   assign hif.pc_stall     = w_pcStall;
   assign hif.stall        = w_stall;
   assign hif.nullify      = w_nullify;
   assign hif.exc_redirect = w_excRedirect;
   assign hif.mdu_busy     = w_mduBusy;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; each task drives one scenario
// and compares {pc_stall, stall, nullify, exc_redirect, mdu_busy} to hand-derived values.
module tb_pipeline_hazard_controller;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   pipeline_hazard_controller_if #(.N_STAGES(4)) hif ();

   pipeline_hazard_controller #(.N_STAGES(4), .MDU_LATENCY(8)) dut (
      .clk   (clk),
      .reset (reset),
      .hif   (hif)
   );

   // Output vector layout: pc_stall, stall[3:0], nullify[3:0], exc_redirect, mdu_busy
   logic [10:0] obs;
   assign obs = {hif.pc_stall, hif.stall, hif.nullify, hif.exc_redirect, hif.mdu_busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clearInputs();
      hif.load_use  = 1'b0;
      hif.mdu_read  = 1'b0;
      hif.mdu_start = 1'b0;
      hif.imem_wait = 1'b0;
      hif.dmem_wait = 1'b0;
      hif.exc_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] exp;
      clearInputs();
      reset = 1'b0;
      step();
      step();
      #1;
      exp = {1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL reset_hold got=%b want=%b", obs, exp);
         failures++;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hif.mdu_start = (i == 1);
         #1;
         checks++;
         if (obs !== exp) begin
            $display("[TB] FAIL init_cycle%0d got=%b want=%b", i, obs, exp);
            failures++;
         end
         step();
      end
      hif.mdu_start = 1'b0;
      #1;
      exp = 11'b0;
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL first_run got=%b want=%b", obs, exp);
         failures++;
      end
   endtask

   task automatic test_load_use();
      logic [10:0] exp;
      hif.load_use = 1'b1;
      #1;
      exp = {1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL load_use got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      hif.load_use = 1'b0;
      #1;
      checks++;
      if (obs !== 11'b0) begin
         $display("[TB] FAIL load_use_after got=%b want=%b", obs, 11'b0);
         failures++;
      end
      step();
   endtask

   task automatic test_mdu();
      logic [10:0] exp;
      logic        busy;
      logic        stallPat;
      hif.mdu_start = 1'b1;
      #1;
      checks++;
      if (obs !== 11'b0) begin
         $display("[TB] FAIL mdu_start_cycle got=%b want=%b", obs, 11'b0);
         failures++;
      end
      step();
      hif.mdu_start = 1'b0;
      for (int c = 11; c <= 19; c++) begin
         hif.mdu_read = (c >= 12);
         busy     = (c <= 18);
         stallPat = (c >= 12) && (c <= 18);
         exp = stallPat ? {1'b1, 4'b0001, 4'b0010, 1'b0, busy}
                        : {1'b0, 4'b0000, 4'b0000, 1'b0, busy};
         #1;
         checks++;
         if (obs !== exp) begin
            $display("[TB] FAIL mdu_cycle%0d got=%b want=%b", c, obs, exp);
            failures++;
         end
         step();
      end
      hif.mdu_read  = 1'b0;
      hif.mdu_start = 1'b1;
      hif.dmem_wait = 1'b1;
      #1;
      exp = {1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL mdu_start_dmem got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      clearInputs();
      #1;
      checks++;
      if (obs !== 11'b0) begin
         $display("[TB] FAIL mdu_not_accepted got=%b want=%b", obs, 11'b0);
         failures++;
      end
      step();
   endtask

   task automatic test_exc_dmem();
      logic [10:0] exp;
      hif.exc_valid = 1'b1;
      hif.dmem_wait = 1'b1;
      #1;
      exp = {1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL exc_with_dmem got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      hif.exc_valid = 1'b0;
      #1;
      exp = {1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL exc_dmem_hold got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      hif.dmem_wait = 1'b0;
      #1;
      exp = {1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL exc_kill got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      #1;
      checks++;
      if (obs !== 11'b0) begin
         $display("[TB] FAIL exc_back_to_run got=%b want=%b", obs, 11'b0);
         failures++;
      end
      step();
   endtask

   task automatic test_fetch_wait();
      logic [10:0] exp;
      hif.imem_wait = 1'b1;
      #1;
      exp = {1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL imem_wait got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      hif.load_use = 1'b1;
      #1;
      exp = {1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL imem_with_load_use got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      clearInputs();
      step();
   endtask

   task automatic test_mid_reset();
      logic [10:0] exp;
      hif.mdu_start = 1'b1;
      step();
      hif.mdu_start = 1'b0;
      step();
      hif.exc_valid = 1'b1;
      step();
      hif.exc_valid = 1'b0;
      hif.dmem_wait = 1'b1;
      step();
      hif.dmem_wait = 1'b0;
      #1;
      exp = {1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL exc_busy_before_reset got=%b want=%b", obs, exp);
         failures++;
      end
      #1;
      reset = 1'b0;
      #1;
      exp = {1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL mid_reset got=%b want=%b", obs, exp);
         failures++;
      end
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
      end
      #1;
      checks++;
      if (obs !== 11'b0) begin
         $display("[TB] FAIL reinit_run got=%b want=%b", obs, 11'b0);
         failures++;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      clearInputs();
      @(negedge clk);
      test_reset();
      test_load_use();
      test_mdu();
      test_exc_dmem();
      test_fetch_wait();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencer for the four pipeline registers of the five-stage core (F/D, D/E, E/M, M/W) and the PC register. It converts hazard and wait indications from the datapath into per-register `stall`/`nullify` controls. It also owns the post-reset flush sequence, the exception flush, and the multicycle MDU busy counter. Each pipeline register's `bubble` input is tied low; this block expresses every hold through `stall`.

## Interface

Parameters:
- `N_STAGES`, default 4: number of pipeline registers. Index 0 = F/D, 1 = D/E, 2 = E/M, 3 = M/W.
- `MDU_LATENCY`, default 8: cycles the MDU is busy after an accepted start (≥1).

Ports:
- `clk`, input, 1: core clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `load_use`, input, 1: D-stage instruction sources the destination of the E-stage load.
- `mdu_read`, input, 1: D-stage instruction reads HI/LO or starts an MDU op.
- `mdu_start`, input, 1: E-stage instruction launches an MDU op.
- `imem_wait`, input, 1: fetch not complete this cycle.
- `dmem_wait`, input, 1: M-stage memory access not complete this cycle.
- `exc_valid`, input, 1: M-stage exception or ERET; redirect this cycle.
- `pc_stall`, output, 1: hold the PC register.
- `stall`, output, N_STAGES: per-register hold.
- `nullify`, output, N_STAGES: per-register load of nullified control.
- `exc_redirect`, output, 1: PC mux selects the exception/ERET target.
- `mdu_busy`, output, 1: MDU counter nonzero.

## Operation

- **Registered state**:
  - FSM with states INIT, RUN and EXC.
  - `init_cnt`, width clog2(N_STAGES+1).
  - `mdu_cnt`, width clog2(MDU_LATENCY+1).
- **Outputs are combinational** from the FSM state, the counters and the current inputs.
- **INIT**:
  - Entered on reset. Stays in INIT for N_STAGES cycles after reset deasserts (`init_cnt` counts up), then goes to RUN.
  - Outputs: `nullify` all ones, `stall` 0, `pc_stall` 1, `exc_redirect` 0.
  - All inputs are ignored, including `mdu_start`.
- **RUN priority** (first match wins):
  1. `exc_valid`: `nullify` all ones, `stall` 0, `pc_stall` 0, `exc_redirect` 1. Next state EXC. `dmem_wait` is ignored.
  2. `dmem_wait`: `stall` all ones, `pc_stall` 1, `nullify` 0.
  3. `load_use` or (`mdu_read` and `mdu_busy`): `pc_stall` 1, `stall[0]` 1, `nullify[1]` 1. All other bits 0. `imem_wait` is ignored.
  4. `imem_wait`: `pc_stall` 1, `nullify[0]` 1.
  5. Otherwise: all outputs 0.
- **EXC**:
  - Kills the fetch that was in flight with the old PC.
  - Apply the RUN priority, then force `nullify[0]` to 1.
  - Next state: EXC if `exc_valid` is asserted, or if `stall[0]` is 1 (stall has precedence at the register, so the kill has not landed yet). Otherwise RUN.
- **MDU counter**:
  - A start is accepted when `mdu_start` is high, the state is not INIT, `exc_valid` is low, and `dmem_wait` is low.
  - An accepted start loads `mdu_cnt` with MDU_LATENCY. This includes a start while already busy, which reloads the counter.
  - Otherwise `mdu_cnt` decrements when nonzero. It keeps counting through stalls and exceptions; an exception does not abort the MDU.
  - `mdu_busy` = (`mdu_cnt` != 0).

## Timing

- **Reset values** (asynchronous, while `reset`=0): state INIT, `init_cnt` 0, `mdu_cnt` 0. Outputs: `nullify` all ones, `pc_stall` 1, `stall` 0, `exc_redirect` 0, `mdu_busy` 0.
- **Reset release**: the first RUN cycle is the (N_STAGES+1)th rising edge after `reset` goes high. A reset asserted mid-operation returns to INIT immediately and clears the MDU counter.
- **Hazard response**: zero-latency. Controls are valid in the same cycle as the inputs and take effect at the next edge.
- **MDU timing**: start accepted at edge t gives `mdu_busy`=1 for exactly MDU_LATENCY cycles after t. An `mdu_read` in the first cycle with `mdu_busy`=0 proceeds without a stall.
- **Exception duration**: `exc_redirect` is a single-cycle pulse per `exc_valid` cycle. The EXC state lasts at least one cycle.
- **Simultaneous events**:
  - `exc_valid` with `dmem_wait`: the exception wins.
  - `load_use` with `imem_wait`: the hazard wins and F/D holds.
  - `dmem_wait` in EXC: EXC is held and F/D is killed on the first cycle without a stall.

## Test plan

- **Reset flush**: release `reset`, all inputs 0. Expect `nullify`=4'b1111 and `pc_stall`=1 for 4 cycles, then all zeros; `mdu_start` pulsed during INIT leaves `mdu_busy`=0.
- **Load-use**: `load_use`=1 for one cycle in RUN. Expect `pc_stall`=1, `stall`=4'b0001, `nullify`=4'b0010; the next cycle is all zeros.
- **MDU**:
  - `mdu_start`=1 at cycle 10. Expect `mdu_busy`=1 on cycles 11–18.
  - `mdu_read`=1 held from cycle 12: stall pattern on 12–18, none on 19.
  - `mdu_start` with `dmem_wait`=1: not accepted.
- **Exception under memory wait**: `exc_valid`=1 and `dmem_wait`=1 together. Expect `nullify`=4'b1111 and `exc_redirect`=1.
  - Next cycle `dmem_wait`=1: `stall`=4'b1111 and state stays EXC.
  - Following cycle with no waits: `nullify`=4'b0001 and state returns to RUN.
- **Fetch wait**: `imem_wait`=1. Expect `pc_stall`=1, `nullify`=4'b0001, `stall`=0.
  - With `load_use` also high: `stall`=4'b0001, `nullify`=4'b0010.
- **Mid-operation reset**: assert `reset` low with `mdu_cnt`=5 while in EXC. Immediately expect `mdu_busy`=0 and INIT outputs.
